// File: rtl/ask4_slicer_mer.sv
// 4-ASK symbol slicer with an adaptive reference level and windowed
// mean-squared-error measurement for MER reporting.
module ask4_slicer_mer #(
  parameter int                 ACC_LOG2 = 18,
  parameter logic signed [17:0] A_INIT   = 18'sd65536
) (
  input  logic               sys_clk,
  input  logic               reset,
  input  logic               sym_clk_ena,
  input  logic               clear,
  input  logic signed [17:0] decision_variable,
  output logic [1:0]         mapper_out,
  output logic signed [17:0] slicer_err,
  output logic signed [17:0] a_hat,
  output logic [17:0]        mean_sq_err,
  output logic               mer_valid,
  output logic               first_window
);

  localparam int ACC_W = 18 + ACC_LOG2 + 1;
  localparam logic [ACC_W-1:0] A_MAX = ACC_W'(131071);
  localparam logic signed [19:0] E_MAX = 20'sd131071;
  localparam logic signed [19:0] E_MIN = -20'sd131071;

  typedef enum logic {S_FIRST, S_RUN} state_t;

  state_t              state_reg, state_next;
  logic [ACC_LOG2-1:0] cnt_reg;
  logic [ACC_W-1:0]    acc_abs_reg, acc_sq_reg;
  logic signed [17:0]  a_hat_reg;
  logic [1:0]          map_reg;
  logic signed [17:0]  err_reg;
  logic [17:0]         mse_reg;
  logic                mer_valid_reg;

  logic signed [19:0]  x_ext, a_ext, lvl1, lvl3, level, e_full;
  logic [1:0]          map_next;
  logic signed [17:0]  e_sat;
  logic signed [35:0]  prod;
  logic [17:0]         e_sq;
  logic [17:0]         x_u, abs_x;
  logic [ACC_W-1:0]    abs_sum, sq_sum, a_calc;
  logic [17:0]         a_new, mse_new;
  logic                sample, window_end;

  assign sample     = sym_clk_ena && !clear;
  assign window_end = sample && (cnt_reg == '1);

  // Slicer decision, reconstructed level, saturated error and its square
  always_comb begin
    x_ext = {{2{decision_variable[17]}}, decision_variable};
    a_ext = {{2{a_hat_reg[17]}}, a_hat_reg};
    lvl1  = a_ext >>> 1;
    lvl3  = a_ext + lvl1;
    if (x_ext >= a_ext) begin
      map_next = 2'b11;
      level    = lvl3;
    end else if (x_ext >= 20'sd0) begin
      map_next = 2'b10;
      level    = lvl1;
    end else if (x_ext >= -a_ext) begin
      map_next = 2'b01;
      level    = -lvl1;
    end else begin
      map_next = 2'b00;
      level    = -lvl3;
    end
    e_full = x_ext - level;
    if (e_full > E_MAX)      e_sat = 18'sd131071;
    else if (e_full < E_MIN) e_sat = -18'sd131071;
    else                     e_sat = e_full[17:0];
    prod = e_sat * e_sat;
    e_sq = prod[34:17];
  end

  // Magnitude of the sample and end-of-window averages (current symbol included)
  always_comb begin
    x_u     = decision_variable;
    abs_x   = x_u[17] ? (~x_u + 18'd1) : x_u;
    abs_sum = acc_abs_reg + ACC_W'(abs_x);
    sq_sum  = acc_sq_reg + ACC_W'(e_sq);
    a_calc  = abs_sum >> ACC_LOG2;
    a_new   = (a_calc > A_MAX) ? 18'd131071 : a_calc[17:0];
    mse_new = 18'(sq_sum >> ACC_LOG2);
  end

  // FSM state register
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) state_reg <= S_FIRST;
    else        state_reg <= state_next;
  end

  // FSM next state: leave S_FIRST at the first completed window, clear restarts
  always_comb begin
    state_next = state_reg;
    if (clear)           state_next = S_FIRST;
    else if (window_end) state_next = S_RUN;
  end

  // FSM output: no trustworthy measurement exists yet while in S_FIRST
  always_comb begin
    first_window = (state_reg == S_FIRST);
  end

  // Datapath registers: decisions, accumulators, window-end updates
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      map_reg       <= 2'b00;
      err_reg       <= '0;
      mse_reg       <= '0;
      mer_valid_reg <= 1'b0;
      a_hat_reg     <= A_INIT;
      cnt_reg       <= '0;
      acc_abs_reg   <= '0;
      acc_sq_reg    <= '0;
    end else begin
      mer_valid_reg <= 1'b0;
      if (clear) begin
        cnt_reg     <= '0;
        acc_abs_reg <= '0;
        acc_sq_reg  <= '0;
        a_hat_reg   <= A_INIT;
      end else if (sym_clk_ena) begin
        map_reg <= map_next;
        err_reg <= e_sat;
        cnt_reg <= cnt_reg + 1'b1;
        if (window_end) begin
          acc_abs_reg <= '0;
          acc_sq_reg  <= '0;
          a_hat_reg   <= a_new;
          // The first window was sliced against A_INIT, so its error is dropped
          if (state_reg == S_RUN) begin
            mse_reg       <= mse_new;
            mer_valid_reg <= 1'b1;
          end
        end else begin
          acc_abs_reg <= abs_sum;
          acc_sq_reg  <= sq_sum;
        end
      end
    end
  end

  assign mapper_out  = map_reg;
  assign slicer_err  = err_reg;
  assign a_hat       = a_hat_reg;
  assign mean_sq_err = mse_reg;
  assign mer_valid   = mer_valid_reg;

endmodule
